// File: rtl/crtc_portctl_pkg.sv
// crtc_pkg: register indices, port offsets and reset values shared by the CRTC port controller.
package crtc_pkg;
    localparam logic [4:0] R_CUR_START = 5'd10;
    localparam logic [4:0] R_CUR_END   = 5'd11;
    localparam logic [4:0] R_START_HI  = 5'd12;
    localparam logic [4:0] R_START_LO  = 5'd13;
    localparam logic [4:0] R_CUR_HI    = 5'd14;
    localparam logic [4:0] R_CUR_LO    = 5'd15;

    localparam logic [15:0] OFS_INDEX  = 16'd0;
    localparam logic [15:0] OFS_DATA   = 16'd1;
    localparam logic [15:0] OFS_MODE   = 16'd4;
    localparam logic [15:0] OFS_COLOR  = 16'd5;
    localparam logic [15:0] OFS_STATUS = 16'd6;

    localparam logic [7:0] RST_CUR_START = 8'h06;
    localparam logic [7:0] RST_CUR_END   = 8'h07;
    localparam logic [7:0] RST_MODE      = 8'h29;
    localparam logic [7:0] RST_COLOR     = 8'h00;

    // Bits a register actually stores; unstored bits read back as zero.
    function automatic logic [7:0] wr_mask(input logic [4:0] idx, input int cw);
        return (idx == R_CUR_START || idx == R_CUR_END) ? 8'h3F :
               (idx == R_START_HI || idx == R_CUR_HI)   ? 8'((16'd1 << (cw - 8)) - 16'd1) :
                                                          8'hFF;
    endfunction
endpackage

// File: rtl/crtc_portctl_sync_edge.sv
// sync_edge: 2-flop synchroniser with a one-cycle rising-edge pulse on the synchronised level.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);
    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_d};
            r_prev <= r_sync[1];
        end
    end

    assign o_level = r_sync[1];
    assign o_rise  = r_sync[1] & ~r_prev;
endmodule

// File: rtl/crtc_portctl.sv
// crtc_portctl: CGA/CRTC port-bus controller with indexed register file, mode/colour
// registers, live status byte and retrace-driven cursor blink.
module crtc_portctl
    import crtc_pkg::*;
#(
    parameter logic [15:0] BASE         = 16'h3D4,
    parameter int          NREGS        = 18,
    parameter int          CURSOR_W     = 11,
    parameter int          BLINK_FRAMES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                port_clk,
    input  logic [15:0]         port,
    input  logic [7:0]          port_o,
    input  logic                port_w,
    output logic [7:0]          port_i,
    input  logic                vretrace,
    output logic [CURSOR_W-1:0] vga_cursor,
    output logic [CURSOR_W-1:0] start_addr,
    output logic [4:0]          cursor_start,
    output logic [4:0]          cursor_end,
    output logic                cursor_visible,
    output logic [7:0]          mode_reg,
    output logic [7:0]          color_reg
);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4:0]    r_index;
    logic [7:0]    r_regs [NREGS];
    logic [7:0]    r_mode;
    logic [7:0]    r_color;
    logic [FW-1:0] r_frames;
    logic          r_phase;

    logic          w_vr_s;
    logic          w_vr_rise;
    logic          w_idx_ok;
    logic          w_wrap;
    logic [15:0]   w_ofs;
    logic [15:0]   w_cur;
    logic [15:0]   w_start;
    logic [7:0]    w_reg_rd;
    logic [7:0]    w_rdata;

    sync_edge u_vr_sync (
        .clock   (clock),
        .reset   (reset),
        .i_d     (vretrace),
        .o_level (w_vr_s),
        .o_rise  (w_vr_rise)
    );

    assign w_ofs    = port - BASE;
    assign w_idx_ok = {1'b0, r_index} < 6'(NREGS);
    assign w_reg_rd = w_idx_ok ? r_regs[r_index] : 8'h00;
    assign w_wrap   = r_frames == FW'(BLINK_FRAMES - 1);

    // Unmapped reads fall through to the current port_i so the bus value is held.
    always_comb begin
        w_rdata = (w_ofs == OFS_INDEX)  ? {3'b000, r_index} :
                  (w_ofs == OFS_DATA)   ? w_reg_rd :
                  (w_ofs == OFS_MODE)   ? r_mode :
                  (w_ofs == OFS_COLOR)  ? r_color :
                  (w_ofs == OFS_STATUS) ? {4'b0000, w_vr_s, 2'b00, w_vr_s} :
                                          port_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_index  <= 5'd0;
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= (i == int'(R_CUR_START)) ? RST_CUR_START :
                             (i == int'(R_CUR_END))   ? RST_CUR_END : 8'h00;
            r_mode   <= RST_MODE;
            r_color  <= RST_COLOR;
            port_i   <= 8'h00;
            r_frames <= '0;
            r_phase  <= 1'b1;
        end else begin
            if (port_clk && port_w) begin
                if (w_ofs == OFS_INDEX) r_index <= port_o[4:0];
                if (w_ofs == OFS_DATA && w_idx_ok) r_regs[r_index] <= port_o & wr_mask(r_index, CURSOR_W);
                if (w_ofs == OFS_MODE) r_mode <= port_o;
                if (w_ofs == OFS_COLOR) r_color <= port_o;
            end
            if (port_clk && !port_w) port_i <= w_rdata;
            if (w_vr_rise) begin
                r_frames <= w_wrap ? '0 : r_frames + FW'(1);
                if (w_wrap) r_phase <= ~r_phase;
            end
        end
    end

    assign w_cur          = {r_regs[R_CUR_HI], r_regs[R_CUR_LO]};
    assign w_start        = {r_regs[R_START_HI], r_regs[R_START_LO]};
    assign vga_cursor     = w_cur[CURSOR_W-1:0];
    assign start_addr     = w_start[CURSOR_W-1:0];
    assign cursor_start   = r_regs[R_CUR_START][4:0];
    assign cursor_end     = r_regs[R_CUR_END][4:0];
    assign cursor_visible = r_phase & ~r_regs[R_CUR_START][5];
    assign mode_reg       = r_mode;
    assign color_reg      = r_color;
endmodule

// File: tb/tb_crtc_portctl.sv
// tb_crtc_portctl: directed bench with a read-data scoreboard for the CRTC port controller.
module tb_crtc_portctl;
    localparam logic [15:0] BASE = 16'h3D4;
    localparam int CW = 11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          port_clk = 1'b0;
    logic [15:0]   port = 16'h0000;
    logic [7:0]    port_o = 8'h00;
    logic          port_w = 1'b0;
    logic          vretrace = 1'b0;
    logic [7:0]    port_i;
    logic [CW-1:0] vga_cursor;
    logic [CW-1:0] start_addr;
    logic [4:0]    cursor_start;
    logic [4:0]    cursor_end;
    logic          cursor_visible;
    logic [7:0]    mode_reg;
    logic [7:0]    color_reg;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

    crtc_portctl #(
        .BASE(BASE), .NREGS(18), .CURSOR_W(CW), .BLINK_FRAMES(2)
    ) dut (
        .clock(clock), .reset(reset), .port_clk(port_clk), .port(port),
        .port_o(port_o), .port_w(port_w), .port_i(port_i), .vretrace(vretrace),
        .vga_cursor(vga_cursor), .start_addr(start_addr), .cursor_start(cursor_start),
        .cursor_end(cursor_end), .cursor_visible(cursor_visible),
        .mode_reg(mode_reg), .color_reg(color_reg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        port = a; port_o = d; port_w = 1'b1; port_clk = 1'b1;
        cyc(1);
        port_clk = 1'b0; port_w = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        exp_q.push_back(exp);
        port = a; port_w = 1'b0; port_clk = 1'b1;
        cyc(1);
        port_clk = 1'b0;
        check(tag, {8'h00, port_i}, {8'h00, exp_q.pop_front()});
    endtask

    task automatic pulse();
        vretrace = 1'b1; cyc(4);
        vretrace = 1'b0; cyc(4);
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("rst_port_i", {8'h00, port_i}, 16'h0000);
        check("rst_visible", {15'h0, cursor_visible}, 16'h0001);
        check("rst_mode_out", {8'h00, mode_reg}, 16'h0029);
        wr(BASE, 8'd10);
        rd("rst_r10", BASE + 16'd1, 8'h06);
        wr(BASE, 8'd11);
        rd("rst_r11", BASE + 16'd1, 8'h07);
        rd("rst_mode", BASE + 16'd4, 8'h29);

        wr(BASE, 8'd14); wr(BASE + 16'd1, 8'hFF);
        wr(BASE, 8'd15); wr(BASE + 16'd1, 8'h34);
        check("vga_cursor", {5'h0, vga_cursor}, 16'h0734);
        wr(BASE, 8'd14);
        rd("r14_masked", BASE + 16'd1, 8'h07);
        wr(BASE, 8'd12); wr(BASE + 16'd1, 8'h05);
        wr(BASE, 8'd13); wr(BASE + 16'd1, 8'hC3);
        check("start_addr", {5'h0, start_addr}, 16'h05C3);

        wr(BASE, 8'd11); wr(BASE + 16'd1, 8'hFF);
        rd("r11_masked", BASE + 16'd1, 8'h3F);
        check("cursor_end", {11'h0, cursor_end}, 16'h001F);
        wr(BASE, 8'd17); wr(BASE + 16'd1, 8'h5A);
        rd("r17_last", BASE + 16'd1, 8'h5A);

        wr(BASE, 8'hF4); wr(BASE + 16'd1, 8'hAA);
        rd("oob_data", BASE + 16'd1, 8'h00);
        rd("index_rd", BASE, 8'h14);
        rd("oob_r17_kept", BASE + 16'd1, 8'h00);
        wr(BASE, 8'd17);
        rd("r17_unchanged", BASE + 16'd1, 8'h5A);

        wr(BASE + 16'd4, 8'h1A); wr(BASE + 16'd5, 8'h3C);
        rd("mode_wr", BASE + 16'd4, 8'h1A);
        check("color_out", {8'h00, color_reg}, 16'h003C);
        rd("color_rd", BASE + 16'd5, 8'h3C);
        rd("unmapped_hold", BASE + 16'd2, 8'h3C);
        wr(BASE + 16'd6, 8'hFF);
        rd("status_idle", BASE + 16'd6, 8'h00);

        pulse(); check("blink_p1", {15'h0, cursor_visible}, 16'h0001);
        pulse(); check("blink_p2", {15'h0, cursor_visible}, 16'h0000);
        pulse(); check("blink_p3", {15'h0, cursor_visible}, 16'h0000);
        pulse(); check("blink_p4", {15'h0, cursor_visible}, 16'h0001);
        wr(BASE, 8'd10); wr(BASE + 16'd1, 8'h20);
        check("cursor_disable", {15'h0, cursor_visible}, 16'h0000);
        check("cursor_start", {11'h0, cursor_start}, 16'h0000);

        vretrace = 1'b1; cyc(3);
        rd("status_high", BASE + 16'd6, 8'h09);
        vretrace = 1'b0; cyc(3);
        rd("status_low", BASE + 16'd6, 8'h00);
        pulse();

        wr(BASE, 8'd15);
        port = BASE + 16'd1; port_o = 8'h55; port_w = 1'b1; port_clk = 1'b1; reset = 1'b1;
        cyc(1);
        port_clk = 1'b0; port_w = 1'b0; reset = 1'b0;
        check("rst2_cursor", {5'h0, vga_cursor}, 16'h0000);
        check("rst2_start", {5'h0, start_addr}, 16'h0000);
        check("rst2_cstart", {11'h0, cursor_start}, 16'h0006);
        check("rst2_cend", {11'h0, cursor_end}, 16'h0007);
        check("rst2_visible", {15'h0, cursor_visible}, 16'h0001);
        check("rst2_mode", {8'h00, mode_reg}, 16'h0029);
        check("rst2_color", {8'h00, color_reg}, 16'h0000);
        check("rst2_port_i", {8'h00, port_i}, 16'h0000);
        rd("rst2_index", BASE, 8'h00);
        wr(BASE, 8'd15);
        rd("rst2_r15", BASE + 16'd1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crtc_portctl.md
# crtc_portctl

Parametrised CGA/CRTC I/O port controller on the CPU port bus, sitting between the core's port interface and the text-mode video generator. It holds an indexed CRTC register file and the mode/colour registers, and returns a live status byte. It also generates the cursor blink phase from the video block's vertical retrace.

## Interface
Parameters:
- BASE, 16'h3D4 — CRTC index port; data port is BASE+1, mode BASE+4, colour BASE+5, status BASE+6.
- NREGS, 18 — implemented CRTC registers, R0..R(NREGS-1); legal range 16..32.
- CURSOR_W, 11 — width of cursor and start-address outputs; legal range 8..14.
- BLINK_FRAMES, 16 — retrace rising edges per blink half-period; minimum 1.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  CPU host clock
- reset  in  1  synchronous active-high reset
- port_clk  in  1  one-cycle port access strobe
- port  in  16  port address
- port_o  in  8  data from CPU
- port_w  in  1  1 = write, 0 = read (sampled with port_clk)
- port_i  out  8  data to CPU, registered
- vretrace  in  1  vertical retrace from video block, asynchronous
- vga_cursor  out  CURSOR_W  cursor character address {R14,R15}
- start_addr  out  CURSOR_W  display start address {R12,R13}
- cursor_start  out  5  R10[4:0]
- cursor_end  out  5  R11[4:0]
- cursor_visible  out  1  blink phase AND NOT R10[5]
- mode_reg  out  8  port BASE+4
- color_reg  out  8  port BASE+5

## Operation
- Index register is 5 bits; a write to BASE stores port_o[4:0]; a read of BASE returns {3'b0, index}.
- Data port write: if index < NREGS, the register is written; otherwise the write is ignored.
- Data port read: if index < NREGS, returns the register; otherwise returns 8'h00.
- R14/R15 feed vga_cursor and R12/R13 feed start_addr. Only the low CURSOR_W bits of the 16-bit concatenation are stored. The upper bits read back as 0.
- R10 bit 5 = cursor disable. Bits 7:6 of R10 and R11 read back as 0.
- Status read at BASE+6 returns {4'b0, vr_s, 2'b0, vr_s}, where vr_s is the synchronised vretrace. The status port is not writable.
- Accesses to any other port address are ignored; on a read of an unmapped address, port_i holds its previous value.
- Blink generator:
  - The frame counter increments on each synchronised vretrace rising edge.
  - When the counter reaches BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
  - cursor_visible = phase & ~R10[5].

## Timing
- A write takes effect on the clock edge where port_clk=1. The dependent output changes in the same cycle (visible the next cycle).
- Read data is valid on port_i one cycle after port_clk, and is held until the next read.
- Read and write in the same cycle cannot occur, because port_w selects between them.
- vretrace passes through a 2-flop synchroniser, so an edge reaches the status port and blink counter 2–3 cycles after it occurs.
- A retrace edge coinciding with a status read is allowed: the read returns the pre-edge synchronised value.
- Reset values: index 0; all CRTC registers 0 except R10=8'h06 and R11=8'h07; mode_reg=8'h29; color_reg=8'h00; port_i=8'h00; frame counter 0; blink phase 1; synchroniser flops 0.
- Reset asserted mid-access wins: a write in the reset cycle is discarded.

## Structure
- Package crtc_pkg holds:
  - register index constants (R_CUR_START=10, R_CUR_END=11, R_START_HI=12, R_START_LO=13, R_CUR_HI=14, R_CUR_LO=15);
  - port offsets (OFS_INDEX=0, OFS_DATA=1, OFS_MODE=4, OFS_COLOR=5, OFS_STATUS=6);
  - reset-value constants.
- One sub-module, sync_edge: 2-flop synchroniser plus rising-edge pulse, used for vretrace.
- Outputs are driven directly from the register array and the blink flops, with no extra pipeline stages.

## Test plan
- After reset, read BASE+1 with index 10, then with index 11 -> 8'h06, then 8'h07; read BASE+4 -> 8'h29; cursor_visible=1.
- Write BASE=14, BASE+1=8'hFF, BASE=15, BASE+1=8'h34 (CURSOR_W=11) -> vga_cursor=11'h734; reading R14 returns 8'h07.
- Write index 20 with NREGS=18, then data 8'hAA -> no register changes; reading the data port returns 8'h00; reading BASE returns 8'h14.
- BLINK_FRAMES=2, 4 vretrace pulses -> phase toggles after pulses 2 and 4; setting R10=8'h20 forces cursor_visible=0 regardless of phase.
- Hold vretrace=1 and read BASE+6 three or more cycles later -> 8'h09; drop vretrace -> 8'h00 after synchroniser delay.
- Assert reset during a data-port write to R15 -> R15 stays 0 and all outputs return to their reset values.
